// File: rtl/jzjpcc_instruction_memory_if.sv
// Request/response bus between jzjpcc_fetch and the instruction memory,
// plus the backdoor load port used to fill the array.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1. A response transfers on a rising edge where
// resp_valid and resp_ready are both 1. Once resp_valid is raised, it and the
// response payload stay stable until that transfer, unless flush or reset
// drops it. flush cancels all outstanding work and blocks acceptance in the
// cycle where it is high.
//
// Signals (master = fetch / bench, slave = memory):
//   req_valid, req_addr[29:0]        master -> slave  read request (word address)
//   req_ready                        slave  -> master request can be taken
//   resp_valid, resp_instruction,
//   resp_error                       slave  -> master read response
//   resp_ready                       master -> slave  response consumed
//   flush                            master -> slave  drop in-flight work
//   load_en, load_addr, load_data    master -> slave  backdoor array write
interface jzjpcc_instruction_memory_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [29:0]           req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_instruction;
  logic                  resp_error;
  logic                  flush;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [31:0]           load_data;

  modport master (
    output req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_instruction, resp_error
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_instruction, resp_error
  );
endinterface

// File: rtl/jzjpcc_instruction_memory.sv
// Word-addressed instruction memory answering jzjpcc_fetch read requests.
// One request is in flight at a time; the response appears WAIT_STATES
// cycles after the cycle following acceptance. Addresses above the
// implemented array return resp_error=1 with a zero instruction.
//
// Ports:
//   clock      core clock, rising edge
//   reset      asynchronous, active-high
//   bus        slave side of jzjpcc_instruction_memory_if (request,
//              response, flush and backdoor load signals)
//   state_dbg  current FSM state (0 idle, 1 wait, 2 response)
module jzjpcc_instruction_memory #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  jzjpcc_instruction_memory_if.slave bus,
  output logic [1:0]                 state_dbg
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST      = CW'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_ON_ACCEPT = (WAIT_STATES > 0) ? CW'(1) : '0;
  // With no wait states an accepted request goes straight to the response.
  localparam logic [1:0]    AFTER_ACCEPT  = (WAIT_STATES > 0) ? WAIT : RESP;

  logic [31:0]   mem [2**ADDR_WIDTH];
  logic [1:0]    state, state_next;
  logic [CW-1:0] wait_cnt, cnt_next;
  logic [31:0]   instr_q;
  logic          error_q;
  logic          accept;
  logic          handshake;
  logic          out_of_range;

  assign out_of_range = (bus.req_addr >> ADDR_WIDTH) != 30'd0;

  // In RESP a new request is taken only when the current response leaves
  // in the same edge, so the single holding register is never overwritten
  // while still owed to fetch.
  assign bus.req_ready = !reset && !bus.flush &&
                         ((state == IDLE) || ((state == RESP) && bus.resp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign handshake     = (state == RESP) && bus.resp_ready;

  assign bus.resp_valid       = (state == RESP);
  assign bus.resp_instruction = instr_q;
  assign bus.resp_error       = error_q;
  assign state_dbg            = state;

  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = AFTER_ACCEPT;
          cnt_next   = CNT_ON_ACCEPT;
        end
      end
      WAIT: begin
        if (wait_cnt == CNT_LAST) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = wait_cnt + CW'(1);
        end
      end
      RESP: begin
        if (handshake) begin
          if (accept) begin
            state_next = AFTER_ACCEPT;
            cnt_next   = CNT_ON_ACCEPT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Flush wins over everything; a handshake in this cycle still completes
    // on the bus but nothing new is started.
    if (bus.flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // The array is read on the accepting edge, so a same-edge backdoor write
  // to the same word is not seen (read-before-write) and later writes cannot
  // disturb the captured response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      instr_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
      if (accept) begin
        error_q <= out_of_range;
        instr_q <= out_of_range ? 32'h0000_0000 : mem[bus.req_addr[ADDR_WIDTH-1:0]];
      end
    end
  end

  // Array contents survive reset; loads are blocked only while reset is high.
  always_ff @(posedge clock) begin
    if (bus.load_en && !reset) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end
endmodule

// File: tb/tb_jzjpcc_instruction_memory.sv
module tb_jzjpcc_instruction_memory;
  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // shared stimulus, driven into both instances
  logic          req_valid  = 1'b0;
  logic [29:0]   req_addr   = '0;
  logic          resp_ready = 1'b0;
  logic          flush      = 1'b0;
  logic          load_en    = 1'b0;
  logic [AW-1:0] load_addr  = '0;
  logic [31:0]   load_data  = '0;

  jzjpcc_instruction_memory_if #(.ADDR_WIDTH(AW)) bus0 ();
  jzjpcc_instruction_memory_if #(.ADDR_WIDTH(AW)) bus1 ();

  assign bus0.req_valid  = req_valid;
  assign bus0.req_addr   = req_addr;
  assign bus0.resp_ready = resp_ready;
  assign bus0.flush      = flush;
  assign bus0.load_en    = load_en;
  assign bus0.load_addr  = load_addr;
  assign bus0.load_data  = load_data;
  assign bus1.req_valid  = req_valid;
  assign bus1.req_addr   = req_addr;
  assign bus1.resp_ready = resp_ready;
  assign bus1.flush      = flush;
  assign bus1.load_en    = load_en;
  assign bus1.load_addr  = load_addr;
  assign bus1.load_data  = load_data;

  logic [1:0] dbg0, dbg1;

  jzjpcc_instruction_memory #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .state_dbg(dbg0));
  jzjpcc_instruction_memory #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .state_dbg(dbg1));

  // index d == WAIT_STATES of that instance
  logic        act_ready [2];
  logic        act_valid [2];
  logic [31:0] act_instr [2];
  logic        act_err   [2];
  logic [1:0]  act_state [2];
  assign act_ready[0] = bus0.req_ready;
  assign act_valid[0] = bus0.resp_valid;
  assign act_instr[0] = bus0.resp_instruction;
  assign act_err[0]   = bus0.resp_error;
  assign act_state[0] = dbg0;
  assign act_ready[1] = bus1.req_ready;
  assign act_valid[1] = bus1.resp_valid;
  assign act_instr[1] = bus1.resp_instruction;
  assign act_err[1]   = bus1.resp_error;
  assign act_state[1] = dbg1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory image written at the edge, read at the preceding negedge, so a
  // same-edge load is naturally invisible to a same-edge request.
  logic [31:0] ref_mem [4096];
  always @(posedge clock) begin
    if (load_en && !reset) ref_mem[load_addr] <= load_data;
  end

  // Expected responses {error, instruction}; at most one is outstanding.
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int age [2] = '{0, 0};

  // Checks this cycle's outputs, then advances the model for the next edge.
  task automatic model_step(input int d);
    int wsv, qs;
    logic ev, er, hs, acc;
    logic [32:0] head, nxt;
    wsv = d;
    qs  = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (reset) begin
      chk($sformatf("rst_ready%0d", d), act_ready[d], 0);
      chk($sformatf("rst_valid%0d", d), act_valid[d], 0);
      chk($sformatf("rst_instr%0d", d), act_instr[d], 0);
      chk($sformatf("rst_err%0d", d), act_err[d], 0);
      chk($sformatf("rst_state%0d", d), act_state[d], 0);
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
      age[d] = 0;
      return;
    end
    ev = (qs > 0) && (age[d] >= wsv);
    er = !flush && ((qs == 0) || (ev && resp_ready));
    chk($sformatf("req_ready%0d", d), act_ready[d], er);
    chk($sformatf("resp_valid%0d", d), act_valid[d], ev);
    if (ev && act_valid[d]) begin
      head = (d == 0) ? exp_q0[0] : exp_q1[0];
      chk($sformatf("resp_data%0d", d), {act_err[d], act_instr[d]}, head);
    end
    hs = ev && resp_ready;
    if (hs) begin
      if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
    end
    acc = req_valid && er;
    if (flush) begin
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end else if (acc) begin
      nxt = (req_addr >= 30'd4096) ? {1'b1, 32'h0} : {1'b0, ref_mem[req_addr[11:0]]};
      if (d == 0) exp_q0.push_back(nxt); else exp_q1.push_back(nxt);
      age[d] = 0;
    end else begin
      age[d]++;
    end
  endtask

  // monitor
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_bus();
    req_valid  = 1'b0;
    flush      = 1'b0;
    load_en    = 1'b0;
    resp_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, cnt;
    tick(3);
    reset = 1'b0;
    tick(1);

    // fill words 0..15 (5 and 7 fixed for directed cases)
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = (i == 5) ? 32'h0050_0093 : (i == 7) ? 32'h1111_1111 : $urandom;
      tick();
    end
    idle_bus();
    tick(2);

    // read of word 5 with one wait state: response two cycles after accept
    req_addr  = 30'd5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!bus1.resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency_ws1", lat + 1, 2);
    chk("read5_instr", bus1.resp_instruction, 32'h0050_0093);
    tick(2);

    // back-pressure, then consume and accept word 6 in the same edge
    resp_ready = 1'b0;
    req_addr   = 30'd5;
    req_valid  = 1'b1;
    tick();
    req_addr = 30'd6;
    tick(5);
    resp_ready = 1'b1;
    #1;
    chk("bp_accept_ready", bus1.req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick(3);

    // back-to-back stream on the zero-wait instance
    cnt = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 30'(i);
      tick();
      if (bus0.resp_valid) cnt++;
    end
    req_valid = 1'b0;
    chk("ws0_stream_count", cnt, 4);
    tick(3);

    // first word beyond the array and a high-bit address
    req_valid = 1'b1;
    req_addr  = 30'h0000_1000;
    tick();
    req_valid = 1'b0;
    tick(3);
    req_valid = 1'b1;
    req_addr  = 30'h2000_0003;
    tick();
    req_valid = 1'b0;
    tick(3);

    // flush while the one-wait instance is waiting, with a request held up
    req_valid = 1'b1;
    req_addr  = 30'd3;
    tick();
    flush    = 1'b1;
    req_addr = 30'd4;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    tick(3);

    // asynchronous reset while a response is being held
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 30'd5;
    tick();
    req_valid = 1'b0;
    tick();
    chk("resp_before_reset", bus1.resp_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid1", bus1.resp_valid, 0);
    chk("async_reset_ready1", bus1.req_ready, 0);
    tick();
    reset      = 1'b0;
    resp_ready = 1'b1;
    tick();

    // same-edge load and read of word 7: old data, then new data
    load_en   = 1'b1;
    load_addr = AW'(7);
    load_data = 32'h2222_2222;
    req_valid = 1'b1;
    req_addr  = 30'd7;
    tick();
    load_en   = 1'b0;
    req_valid = 1'b0;
    tick();
    chk("rbw_old_data", bus1.resp_instruction, 32'h1111_1111);
    tick(2);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rbw_new_data", bus1.resp_instruction, 32'h2222_2222);
    tick(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 99) < 70);
      req_addr   = ($urandom_range(0, 9) == 0) ? 30'($urandom_range(4096, 1 << 29))
                                                : 30'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 99) < 60);
      flush      = ($urandom_range(0, 99) < 5);
      load_en    = ($urandom_range(0, 99) < 20);
      load_addr  = AW'($urandom_range(0, 15));
      load_data  = $urandom;
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    idle_bus();
    tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
